// File: rtl/rheed_crop_stream.sv
// rheed_crop_stream: crops (and optionally 2x decimates) a raster pixel stream packed into wide beats.
module rheed_crop_stream #(
  parameter int DATA_WIDTH      = 256,
  parameter int PIXEL_BIT_WIDTH = 8,
  parameter int OUT_BIT_WIDTH   = 10,
  parameter int IN_ROWS         = 20,
  parameter int IN_COLS         = 20,
  parameter int OUT_ROWS        = 20,
  parameter int OUT_COLS        = 20
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ap_start,
  output logic                       ap_idle,
  output logic                       ap_done,
  output logic                       cfg_err,
  input  logic [$clog2(IN_COLS)-1:0] crop_x0,
  input  logic [$clog2(IN_ROWS)-1:0] crop_y0,
  input  logic                       dec_x,
  input  logic                       dec_y,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [OUT_BIT_WIDTH-1:0]   m_axis_tdata,
  output logic                       m_axis_tlast
);
  localparam int PPB  = DATA_WIDTH / PIXEL_BIT_WIDTH;
  localparam int LW   = PPB > 1 ? $clog2(PPB) : 1;
  localparam int XW   = $clog2(IN_COLS);
  localparam int YW   = $clog2(IN_ROWS);
  localparam int NOUT = OUT_ROWS * OUT_COLS;
  localparam int NW   = $clog2(NOUT + 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t                     state_q, state_d;
  logic [XW-1:0]              x0_q, x0_d, col_q, col_d;
  logic [YW-1:0]              y0_q, y0_d, row_q, row_d;
  logic                       dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic [DATA_WIDTH-1:0]      hold_q, hold_d;
  logic                       hold_v_q, hold_v_d;
  logic [LW-1:0]              lane_q, lane_d;
  logic                       out_v_q, out_v_d, out_last_q, out_last_d;
  logic [OUT_BIT_WIDTH-1:0]   out_data_q, out_data_d;
  logic [NW-1:0]              out_cnt_q, out_cnt_d;
  logic [PIXEL_BIT_WIDTH-1:0] pix;
  logic [31:0]                sx, sy;
  logic                       start, bad, keep, adv, load, last_lane, last_col, frame_end, s_fire;
  always_comb begin
    start     = state_q == IDLE && ap_start;
    bad       = 32'(crop_x0) + (dec_x ? 32'(2 * OUT_COLS) : 32'(OUT_COLS)) > 32'(IN_COLS) ||
                32'(crop_y0) + (dec_y ? 32'(2 * OUT_ROWS) : 32'(OUT_ROWS)) > 32'(IN_ROWS);
    sx        = dx_q ? 32'(2 * OUT_COLS) : 32'(OUT_COLS);
    sy        = dy_q ? 32'(2 * OUT_ROWS) : 32'(OUT_ROWS);
    pix       = hold_q[lane_q*PIXEL_BIT_WIDTH +: PIXEL_BIT_WIDTH];
    // window membership plus decimation parity relative to the window origin
    keep      = hold_v_q && !err_q &&
                32'(col_q) >= 32'(x0_q) && 32'(col_q) < 32'(x0_q) + sx &&
                32'(row_q) >= 32'(y0_q) && 32'(row_q) < 32'(y0_q) + sy &&
                !(dx_q && (col_q[0] ^ x0_q[0])) && !(dy_q && (row_q[0] ^ y0_q[0]));
    adv       = hold_v_q && (!keep || !out_v_q || m_axis_tready);
    load      = adv && keep;
    last_lane = lane_q == LW'(PPB - 1);
    last_col  = col_q == XW'(IN_COLS - 1);
    frame_end = adv && last_lane && last_col && row_q == YW'(IN_ROWS - 1);
    // no beat of the next frame is taken while the final pixel drains out of the holding register
    s_axis_tready = state_q == RUN && (!hold_v_q || (adv && last_lane && !frame_end));
    s_fire    = s_axis_tvalid && s_axis_tready;
    x0_d      = start ? crop_x0 : x0_q;
    y0_d      = start ? crop_y0 : y0_q;
    dx_d      = start ? dec_x : dx_q;
    dy_d      = start ? dec_y : dy_q;
    err_d     = start ? bad : err_q;
    hold_d    = s_fire ? s_axis_tdata : hold_q;
    hold_v_d  = s_fire ? 1'b1 : (adv && last_lane) ? 1'b0 : hold_v_q;
    lane_d    = adv ? (last_lane ? '0 : lane_q + LW'(1)) : lane_q;
    col_d     = adv ? (last_col ? '0 : col_q + XW'(1)) : col_q;
    row_d     = frame_end ? '0 : (adv && last_col) ? row_q + YW'(1) : row_q;
    out_v_d    = load ? 1'b1 : (out_v_q && m_axis_tready) ? 1'b0 : out_v_q;
    out_data_d = load ? OUT_BIT_WIDTH'(pix) << (OUT_BIT_WIDTH - PIXEL_BIT_WIDTH) : out_data_q;
    out_last_d = load ? out_cnt_q == NW'(NOUT - 1) : out_last_q;
    out_cnt_d  = start ? '0 : load ? out_cnt_q + NW'(1) : out_cnt_q;
    state_d    = start ? RUN : frame_end ? DRAIN : (state_q == DRAIN && !out_v_q) ? IDLE : state_q;
    ap_idle       = state_q == IDLE;
    ap_done       = state_q == DRAIN && !out_v_q;
    cfg_err       = err_q;
    m_axis_tvalid = out_v_q;
    m_axis_tdata  = out_data_q;
    m_axis_tlast  = out_last_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      x0_q       <= '0;
      y0_q       <= '0;
      dx_q       <= 1'b0;
      dy_q       <= 1'b0;
      err_q      <= 1'b0;
      hold_q     <= '0;
      hold_v_q   <= 1'b0;
      lane_q     <= '0;
      col_q      <= '0;
      row_q      <= '0;
      out_v_q    <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      out_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      err_q      <= err_d;
      hold_q     <= hold_d;
      hold_v_q   <= hold_v_d;
      lane_q     <= lane_d;
      col_q      <= col_d;
      row_q      <= row_d;
      out_v_q    <= out_v_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      out_cnt_q  <= out_cnt_d;
    end
  end
endmodule

// File: tb/tb_rheed_crop_stream.sv
// tb_rheed_crop_stream: directed frames on a 4x8 image cropped to 2x2, checked against a raster-walk model.
module tb_rheed_crop_stream;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ap_start = 1'b0;
  logic        ap_idle, ap_done, cfg_err;
  logic [2:0]  crop_x0 = '0;
  logic [1:0]  crop_y0 = '0;
  logic        dec_x = 1'b0, dec_y = 1'b0;
  logic        s_axis_tvalid = 1'b0, s_axis_tready;
  logic [31:0] s_axis_tdata = '0;
  logic        m_axis_tvalid, m_axis_tlast;
  logic        m_axis_tready = 1'b1;
  logic [9:0]  m_axis_tdata;
  rheed_crop_stream #(
    .DATA_WIDTH(32), .PIXEL_BIT_WIDTH(8), .OUT_BIT_WIDTH(10),
    .IN_ROWS(4), .IN_COLS(8), .OUT_ROWS(2), .OUT_COLS(2)
  ) dut (
    .clk(clk), .reset(reset), .ap_start(ap_start), .ap_idle(ap_idle), .ap_done(ap_done),
    .cfg_err(cfg_err), .crop_x0(crop_x0), .crop_y0(crop_y0), .dec_x(dec_x), .dec_y(dec_y),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast)
  );
  always #5 clk = ~clk;
  int vecs = 0, errs = 0;
  int exp_q[$];
  int exp_total = 0, out_idx = 0, out_cnt = 0, done_cnt = 0, beats = 0, stall_left = 0;
  bit prev_stall = 0, prev_last = 0;
  int prev_data = 0;
  task automatic chk(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  // expected output stream from the crop/decimate rules applied to a row*8+col image
  task automatic build(input int x0, input int y0, input int dx, input int dy);
    int sx, sy;
    sx = 2 << dx;
    sy = 2 << dy;
    exp_q.delete();
    if (x0 + sx <= 8 && y0 + sy <= 4)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 8; c++)
          if (c >= x0 && c < x0 + sx && r >= y0 && r < y0 + sy &&
              (dx == 0 || (c - x0) % 2 == 0) && (dy == 0 || (r - y0) % 2 == 0))
            exp_q.push_back((r * 8 + c) << 2);
    exp_total = exp_q.size();
    out_idx = 0;
  endtask
  always @(negedge clk) begin
    if (prev_stall) begin
      chk("stall_tvalid", int'(m_axis_tvalid), 1);
      chk("stall_tdata", int'(m_axis_tdata), prev_data);
      chk("stall_tlast", int'(m_axis_tlast), int'(prev_last));
    end
    m_axis_tready = !(stall_left > 0 && m_axis_tvalid && out_idx == 1);
    prev_stall = m_axis_tvalid && !m_axis_tready;
    if (prev_stall) stall_left--;
    prev_data = int'(m_axis_tdata);
    prev_last = m_axis_tlast;
    if (m_axis_tvalid && m_axis_tready && !reset) begin
      out_cnt++;
      if (exp_q.size() == 0) chk("unexpected_out", int'(m_axis_tdata), -1);
      else begin
        chk("tdata", int'(m_axis_tdata), exp_q.pop_front());
        chk("tlast", int'(m_axis_tlast), int'(out_idx == exp_total - 1));
      end
      out_idx++;
    end
    if (ap_done) done_cnt++;
  end
  task automatic start_frame(input int x0, input int y0, input int dx, input int dy);
    crop_x0 = 3'(x0);
    crop_y0 = 2'(y0);
    dec_x = dx[0];
    dec_y = dy[0];
    build(x0, y0, dx, dy);
    out_cnt = 0;
    beats = 0;
    ap_start = 1'b1;
    @(posedge clk); #1;
    ap_start = 1'b0;
    crop_x0 = 3'd0;
    crop_y0 = 2'd0;
    dec_x = 1'b0;
    dec_y = 1'b0;
    chk("ap_idle_run", int'(ap_idle), 0);
  endtask
  task automatic send_beats(input int n);
    for (int b = 0; b < n; b++) begin
      int r, c0, guard;
      bit acc;
      r = b / 2;
      c0 = (b % 2) * 4;
      for (int k = 0; k < 4; k++) s_axis_tdata[8*k +: 8] = 8'(r * 8 + c0 + k);
      s_axis_tvalid = 1'b1;
      acc = 0;
      guard = 0;
      while (!acc && guard < 200) begin
        @(negedge clk); #1;
        acc = s_axis_tready;
        @(posedge clk); #1;
        guard++;
      end
      if (!acc) begin
        chk("beat_timeout", b, -1);
        break;
      end
      beats++;
    end
    s_axis_tvalid = 1'b0;
  endtask
  task automatic run_frame(input string tag, input int x0, input int y0, input int dx, input int dy, input int err);
    int d0, guard;
    d0 = done_cnt;
    start_frame(x0, y0, dx, dy);
    send_beats(8);
    guard = 0;
    while (done_cnt == d0 && guard < 300) begin
      @(negedge clk); #1;
      guard++;
    end
    repeat (5) @(posedge clk);
    #1;
    chk({tag, "_done_once"}, done_cnt - d0, 1);
    chk({tag, "_beats"}, beats, 8);
    chk({tag, "_outputs"}, out_cnt, exp_total);
    chk({tag, "_left"}, exp_q.size(), 0);
    chk({tag, "_cfg_err"}, int'(cfg_err), err);
    chk({tag, "_idle"}, int'(ap_idle), 1);
  endtask
  initial begin
    int lit1[4] = '{36, 40, 68, 72};
    int lit2[4] = '{8, 16, 72, 80};
    int d0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ap_idle", int'(ap_idle), 1);
    chk("rst_ap_done", int'(ap_done), 0);
    chk("rst_s_tready", int'(s_axis_tready), 0);
    chk("rst_m_tvalid", int'(m_axis_tvalid), 0);
    chk("rst_m_tlast", int'(m_axis_tlast), 0);
    chk("rst_m_tdata", int'(m_axis_tdata), 0);
    chk("rst_cfg_err", int'(cfg_err), 0);
    reset = 1'b0;
    @(posedge clk); #1;
    build(1, 1, 0, 0);
    chk("model1_len", exp_q.size(), 4);
    for (int i = 0; i < 4; i++) chk("model1_val", exp_q[i], lit1[i]);
    build(2, 0, 1, 1);
    chk("model2_len", exp_q.size(), 4);
    for (int i = 0; i < 4; i++) chk("model2_val", exp_q[i], lit2[i]);
    build(7, 0, 0, 0);
    chk("model3_len", exp_q.size(), 0);
    exp_q.delete();
    run_frame("crop", 1, 1, 0, 0, 0);
    run_frame("dec", 2, 0, 1, 1, 0);
    run_frame("err", 7, 0, 0, 0, 1);
    stall_left = 5;
    run_frame("stall", 1, 1, 0, 0, 0);
    chk("stall_used", stall_left, 0);
    d0 = done_cnt;
    start_frame(1, 1, 0, 0);
    send_beats(3);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_idle", int'(ap_idle), 1);
    chk("midrst_tvalid", int'(m_axis_tvalid), 0);
    reset = 1'b0;
    exp_q.delete();
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_no_done", done_cnt - d0, 0);
    run_frame("after_rst", 1, 1, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/rheed_crop_stream.md
RHEED_CROP_STREAM -- requirements
Module: rheed_crop_stream

Interface
REQ-001 Parameter DATA_WIDTH, default 256: input beat width in bits; SHALL be a multiple of PIXEL_BIT_WIDTH.
REQ-002 Parameter PIXEL_BIT_WIDTH, default 8: input pixel container width; PPB = DATA_WIDTH/PIXEL_BIT_WIDTH pixels per beat.
REQ-003 Parameter OUT_BIT_WIDTH, default 10: output pixel width; SHALL be >= PIXEL_BIT_WIDTH.
REQ-004 Parameters IN_ROWS/IN_COLS, default 20/20: input frame size; IN_COLS SHALL be a multiple of PPB.
REQ-005 Parameters OUT_ROWS/OUT_COLS, default 20/20: cropped output frame size.
REQ-006 clk  in  1  single clock; all logic on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 ap_start  in  1  frame start request, sampled only in IDLE.
REQ-009 ap_idle  out  1  high while in IDLE.
REQ-010 ap_done  out  1  one-cycle pulse at frame completion.
REQ-011 cfg_err  out  1  latched crop-window error for current/last frame.
REQ-012 crop_x0  in  $clog2(IN_COLS)  window left column.
REQ-013 crop_y0  in  $clog2(IN_ROWS)  window top row.
REQ-014 dec_x, dec_y  in  1 each  keep every 2nd column/row of window when set.
REQ-015 s_axis_tvalid/s_axis_tready/s_axis_tdata  in/out/in  1/1/DATA_WIDTH  input beats.
REQ-016 m_axis_tvalid/m_axis_tready/m_axis_tdata/m_axis_tlast  out/in/out/out  1/1/OUT_BIT_WIDTH/1  output pixels.

Function
REQ-017 States SHALL be IDLE, RUN, DRAIN; IDLE->RUN on ap_start; RUN->DRAIN when last input pixel (row IN_ROWS-1, col IN_COLS-1) is consumed; DRAIN->IDLE when output register empty, asserting ap_done that cycle.
REQ-018 ap_start in RUN/DRAIN SHALL be ignored.
REQ-019 On IDLE->RUN, crop_x0, crop_y0, dec_x, dec_y SHALL be latched; later input changes have no effect on the frame.
REQ-020 Window span SX = OUT_COLS<<dec_x, SY = OUT_ROWS<<dec_y; if x0+SX>IN_COLS or y0+SY>IN_ROWS, cfg_err SHALL set at latch, frame SHALL be fully consumed with no output, then ap_done.
REQ-021 cfg_err SHALL clear on next accepted ap_start with valid window.
REQ-022 Pixel order within beat: lane 0 (bits [PIXEL_BIT_WIDTH-1:0]) first, raster order, row-major.
REQ-023 Beat held in holding register; one lane evaluated per cycle; s_axis_tready high only in RUN when holding empty or last lane advancing that cycle (no bubble between beats).
REQ-024 Pixel kept iff x0<=col<x0+SX, y0<=row<y0+SY, and (dec_x=0 or (col-x0) even) and (dec_y=0 or (row-y0) even).
REQ-025 Discarded pixels SHALL advance 1/cycle regardless of m_axis_tready.
REQ-026 Kept pixel advances only when output register empty or being accepted same cycle; full throughput 1 pixel/cycle with m_axis_tready high.
REQ-027 m_axis_tdata = pixel << (OUT_BIT_WIDTH-PIXEL_BIT_WIDTH), MSB-aligned, low bits zero.
REQ-028 Latency: beat accepted at edge E; kept lane-0 pixel on m_axis_tvalid in cycle after edge E+1.
REQ-029 m_axis_tvalid/tdata/tlast SHALL hold stable while tvalid high and tready low.
REQ-030 m_axis_tlast high only on pixel OUT_ROWS*OUT_COLS of frame.
REQ-031 Column counter wraps IN_COLS-1->0 incrementing row; row counter clears at frame end.

Reset
REQ-032 reset SHALL return to IDLE in one cycle, discard held beat and output pixel, clear counters and cfg_err.
REQ-033 Reset values: ap_idle=1, ap_done=0, s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
REQ-034 Reset mid-frame SHALL produce no ap_done; next ap_start starts fresh frame at row 0 col 0.

Verification (DATA_WIDTH=32, PIXEL_BIT_WIDTH=8, OUT_BIT_WIDTH=10, IN 4x8, OUT 2x2, pixel=row*8+col)
REQ-035 x0=1,y0=1, no decimation, tready=1 -> outputs 36,40,68,72; tlast on 72; ap_done once after 8 beats.
REQ-036 x0=2,y0=0,dec_x=dec_y=1 -> outputs 8,16,72,80; tlast on 80.
REQ-037 x0=7,y0=0 -> cfg_err=1, 8 beats accepted, zero output beats, ap_done pulse.
REQ-038 Case REQ-035 with tready low 5 cycles at 2nd output -> tdata 40 held stable, no loss/duplication, same sequence.
REQ-039 reset after 3 beats accepted -> ap_idle=1, m_axis_tvalid=0 next cycle; new frame repeats REQ-035 exactly.
